// File: rtl/baud_rate_gen.sv
// Baud-rate generator: divides m_clk by a 16-bit divisor to produce a 16x
// oversampling tick, a per-bit tick and the sample index within the bit.
module baud_rate_gen (
    input  logic       m_clk,
    input  logic       reset,
    input  logic [7:0] divisor_1,
    input  logic [7:0] divisor_2,
    input  logic       enable,
    output logic       tick_16x,
    output logic       baud_tick,
    output logic [3:0] sample_idx,
    output logic       active
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_div_q;
    logic [15:0] r_cnt;
    logic [3:0]  r_idx;
    logic        r_tick;
    logic        r_baud;

    logic [0:0]  w_state_next;
    logic [15:0] w_cnt_next;
    logic [3:0]  w_idx_next;
    logic        w_tick_next;
    logic        w_baud_next;

    logic [15:0] w_div;
    logic        w_div_change;
    logic        w_cnt_wrap;

    assign w_div        = {divisor_2, divisor_1};
    assign w_div_change = (w_div != r_div_q);
    // Only evaluated in RUN, where r_div_q is known to be non-zero.
    assign w_cnt_wrap   = (r_cnt == (r_div_q - 16'd1));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_tick_next  = 1'b0;
        w_baud_next  = 1'b0;

        if (w_div_change || (w_div == 16'd0)) begin
            // A new or zero divisor restarts the bit timing from scratch.
            w_state_next = ST_IDLE;
            w_cnt_next   = 16'd0;
            w_idx_next   = 4'd0;
        end else if (r_state == ST_IDLE) begin
            // Counters stay frozen so a paused bit resumes where it stopped.
            if (enable) begin
                w_state_next = ST_RUN;
            end
        end else if (!enable) begin
            w_state_next = ST_IDLE;
        end else if (w_cnt_wrap) begin
            w_cnt_next  = 16'd0;
            w_idx_next  = r_idx + 4'd1;
            w_tick_next = 1'b1;
            w_baud_next = (r_idx == 4'd15);
        end else begin
            w_cnt_next = r_cnt + 16'd1;
        end
    end

    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div_q <= w_div;
            r_cnt   <= 16'd0;
            r_idx   <= 4'd0;
            r_tick  <= 1'b0;
            r_baud  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div_q <= w_div;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_tick  <= w_tick_next;
            r_baud  <= w_baud_next;
        end
    end

    assign tick_16x   = r_tick;
    assign baud_tick  = r_baud;
    assign sample_idx = r_idx;
    assign active     = (r_state == ST_RUN);

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: a cycle model feeds a scoreboard queue of
// expected outputs, plus direct measurements of tick spacing per scenario.
module tb_baud_rate_gen;

    logic       m_clk = 1'b0;
    logic       reset;
    logic [7:0] divisor_1;
    logic [7:0] divisor_2;
    logic       enable;
    logic       tick_16x;
    logic       baud_tick;
    logic [3:0] sample_idx;
    logic       active;

    baud_rate_gen dut (
        .m_clk      (m_clk),
        .reset      (reset),
        .divisor_1  (divisor_1),
        .divisor_2  (divisor_2),
        .enable     (enable),
        .tick_16x   (tick_16x),
        .baud_tick  (baud_tick),
        .sample_idx (sample_idx),
        .active     (active)
    );

    always #5 m_clk = ~m_clk;

    typedef struct packed {
        logic       tick;
        logic       baud;
        logic [3:0] idx;
        logic       act;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_divq;
    logic        m_run;
    logic [15:0] m_cnt;
    logic [3:0]  m_idx;
    logic        m_tick;
    logic        m_baud;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model with the current inputs, run one clock, compare.
    task automatic cycle();
        logic [15:0] d;
        exp_t e;
        d = {divisor_2, divisor_1};
        m_tick = 1'b0;
        m_baud = 1'b0;
        if (reset) begin
            m_run = 1'b0; m_cnt = 16'd0; m_idx = 4'd0; m_divq = d;
        end else if (d != m_divq) begin
            m_divq = d; m_run = 1'b0; m_cnt = 16'd0; m_idx = 4'd0;
        end else if (d == 16'd0) begin
            m_run = 1'b0; m_cnt = 16'd0; m_idx = 4'd0;
        end else if (!m_run) begin
            m_run = enable;
        end else if (!enable) begin
            m_run = 1'b0;
        end else if ({1'b0, m_cnt} + 17'd1 == {1'b0, m_divq}) begin
            m_cnt  = 16'd0;
            m_tick = 1'b1;
            m_baud = (m_idx == 4'd15);
            m_idx  = m_idx + 4'd1;
        end else begin
            m_cnt = m_cnt + 16'd1;
        end
        exp_q.push_back('{tick: m_tick, baud: m_baud, idx: m_idx, act: m_run});
        @(posedge m_clk);
        #1;
        e = exp_q.pop_front();
        check("tick_16x", 32'(tick_16x), 32'(e.tick));
        check("baud_tick", 32'(baud_tick), 32'(e.baud));
        check("sample_idx", 32'(sample_idx), 32'(e.idx));
        check("active", 32'(active), 32'(e.act));
        if (baud_tick === 1'b1) check("baud_implies_tick", 32'(tick_16x), 32'd1);
        $display("cyc t=%0t D=%04h en=%0b rst=%0b tick=%0b baud=%0b idx=%0d act=%0b",
                 $time, d, enable, reset, tick_16x, baud_tick, sample_idx, active);
    endtask

    task automatic count_to_tick(input int bound, output int n);
        n = 0;
        do begin cycle(); n++; end while (tick_16x !== 1'b1 && n < bound);
    endtask

    task automatic count_to_baud(input int bound, output int n);
        n = 0;
        do begin cycle(); n++; end while (baud_tick !== 1'b1 && n < bound);
    endtask

    task automatic wait_idx(input logic [3:0] v, input int bound);
        int n;
        n = 0;
        while (sample_idx !== v && n < bound) begin cycle(); n++; end
        check("wait_idx", 32'(sample_idx), 32'(v));
    endtask

    initial begin
        int n;
        int cnt_t;
        int cnt_a;

        // Reset with D=4 and enable already high
        reset = 1'b1; divisor_2 = 8'h00; divisor_1 = 8'h04; enable = 1'b1;
        cycle(); cycle();
        check("reset_active", 32'(active), 32'd0);
        reset = 1'b0;
        cycle();
        check("active_after_1_edge", 32'(active), 32'd1);
        count_to_tick(100, n);  check("d4_first_tick", n, 4);
        count_to_tick(100, n);  check("d4_tick_period", n, 4);
        count_to_baud(200, n);
        count_to_baud(200, n);  check("d4_baud_period", n, 64);
        check("d4_baud_idx0", 32'(sample_idx), 32'd0);

        // D=1: tick held high, baud once in 16
        divisor_1 = 8'h01;
        count_to_baud(100, n);
        count_to_baud(100, n);  check("d1_baud_period", n, 16);
        cycle();
        check("d1_tick_high", 32'(tick_16x), 32'd1);

        // D=10, divisor change mid-bit
        divisor_1 = 8'h0A;
        wait_idx(4'd7, 400);
        divisor_1 = 8'h05;
        cycle();
        check("chg_idx", 32'(sample_idx), 32'd0);
        check("chg_active", 32'(active), 32'd0);
        check("chg_tick", 32'(tick_16x), 32'd0);
        count_to_baud(200, n);  check("chg_first_baud", n, 81);

        // D=3, pause enable at sample_idx 9
        divisor_1 = 8'h03;
        wait_idx(4'd9, 200);
        enable = 1'b0;
        cnt_t = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (tick_16x === 1'b1 || baud_tick === 1'b1) cnt_t++;
        end
        check("pause_no_ticks", cnt_t, 0);
        check("pause_idx_held", 32'(sample_idx), 32'd9);
        check("pause_active", 32'(active), 32'd0);
        enable = 1'b1;
        cnt_t = 0; n = 0;
        do begin
            cycle(); n++;
            if (tick_16x === 1'b1) cnt_t++;
        end while (baud_tick !== 1'b1 && n < 200);
        check("resume_ticks_to_baud", cnt_t, 7);

        // D=0 for 100 cycles, then D=2
        divisor_1 = 8'h00;
        cnt_t = 0; cnt_a = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (tick_16x === 1'b1 || baud_tick === 1'b1) cnt_t++;
            if (active === 1'b1) cnt_a++;
        end
        check("d0_no_ticks", cnt_t, 0);
        check("d0_never_active", cnt_a, 0);
        divisor_1 = 8'h02;
        count_to_tick(20, n);
        count_to_tick(20, n);   check("d2_tick_period", n, 2);

        // D=8, reset pulse mid-bit
        divisor_1 = 8'h08;
        wait_idx(4'd12, 300);
        reset = 1'b1;
        cycle();
        check("rst_tick", 32'(tick_16x), 32'd0);
        check("rst_baud", 32'(baud_tick), 32'd0);
        check("rst_idx", 32'(sample_idx), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        reset = 1'b0;
        count_to_tick(50, n);   check("rst_first_tick", n, 9);

        // D=FFFF: longest period without wrap
        divisor_2 = 8'hFF; divisor_1 = 8'hFF;
        cycle();
        count_to_tick(70000, n); check("dffff_first_tick", n, 65536);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
